// File: rtl/can_bit_destuffing.sv
// CAN receive-side bit destuffer: drops the complementary bit that follows each
// run of STUFF_LEN identical bits and flags a stuff error on a run of STUFF_LEN+1.
module can_bit_destuffing #(
  parameter int STUFF_LEN = 5,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_out,
  output logic             bit_out_valid,
  output logic             stuff_drop,
  output logic             stuff_error,
  output logic [CNT_W-1:0] out_count
);

  localparam int RUN_W = $clog2(STUFF_LEN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STUFF_LEN);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] ERROR  = 2'd2;

  logic [1:0]       state;
  logic [RUN_W-1:0] run_cnt;
  logic             last_bit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // An error state swallows all bits until the frame controller drops enable.
  logic take_bit;
  assign take_bit = enable && bit_valid && (state != ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      run_cnt       <= '0;
      last_bit      <= 1'b1;
      bit_out       <= 1'b1;
      bit_out_valid <= 1'b0;
      stuff_drop    <= 1'b0;
      stuff_error   <= 1'b0;
      out_count     <= '0;
    end else begin
      bit_out_valid <= 1'b0;
      stuff_drop    <= 1'b0;
      if (!enable) begin
        state       <= IDLE;
        run_cnt     <= '0;
        last_bit    <= 1'b1;
        out_count   <= '0;
        stuff_error <= 1'b0;
      end else begin
        if (state == IDLE)
          state <= ACTIVE;
        if (take_bit) begin
          if (run_cnt < RUN_MAX) begin
            bit_out       <= bit_in;
            bit_out_valid <= 1'b1;
            run_cnt       <= (bit_in == last_bit && run_cnt != '0) ? run_cnt + 1'b1 : RUN_ONE;
            last_bit      <= bit_in;
            out_count     <= sat_inc(out_count);
          end else if (bit_in != last_bit) begin
            // The stuff bit itself opens the next run.
            stuff_drop <= 1'b1;
            run_cnt    <= RUN_ONE;
            last_bit   <= bit_in;
          end else begin
            stuff_error <= 1'b1;
            state       <= ERROR;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_can_bit_destuffing.sv
// Directed testbench for can_bit_destuffing; expected vectors are hand-derived.
module tb_can_bit_destuffing;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       bit_in;
  logic       bit_valid;
  logic       bit_out;
  logic       bit_out_valid;
  logic       stuff_drop;
  logic       stuff_error;
  logic [7:0] out_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  can_bit_destuffing #(.STUFF_LEN(5), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .enable(enable), .bit_in(bit_in), .bit_valid(bit_valid),
    .bit_out(bit_out), .bit_out_valid(bit_out_valid), .stuff_drop(stuff_drop),
    .stuff_error(stuff_error), .out_count(out_count)
  );

  // Drives n bits MSB first with enable=1, capturing outputs 1 cycle after each bit.
  task automatic feed(input int n, input logic [63:0] bits, input int gap,
                      output logic [63:0] vv, output logic [63:0] dv,
                      output logic [63:0] sv, output logic [63:0] ev);
    vv = '0; dv = '0; sv = '0; ev = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      enable    = 1'b1;
      bit_in    = bits[n-1-i];
      bit_valid = 1'b1;
      @(posedge clk);
      #1;
      vv[n-1-i] = bit_out_valid;
      dv[n-1-i] = bit_out;
      sv[n-1-i] = stuff_drop;
      ev[n-1-i] = stuff_error;
      if (gap > 0) begin
        @(negedge clk);
        bit_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic go_idle();
    @(negedge clk);
    enable    = 1'b0;
    bit_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bit_out, bit_out_valid, stuff_drop, stuff_error, out_count} !== {4'b1000, 8'd0}) begin
      failures++;
      $display("FAIL reset_state: got out=%b vld=%b drop=%b err=%b cnt=%0d, want out=1 vld=0 drop=0 err=0 cnt=0",
               bit_out, bit_out_valid, stuff_drop, stuff_error, out_count);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_stuff();
    logic [63:0] vv, dv, sv, ev;
    feed(7, 64'b0000010, 0, vv, dv, sv, ev);
    checks++;
    if (vv[6:0] !== 7'b1111101) begin failures++; $display("FAIL t1_valid: got %b want 1111101", vv[6:0]); end
    checks++;
    if (dv[6:0] !== 7'b0000000) begin failures++; $display("FAIL t1_data: got %b want 0000000", dv[6:0]); end
    checks++;
    if (sv[6:0] !== 7'b0000010 || ev[6:0] !== 7'b0) begin
      failures++; $display("FAIL t1_drop_err: got drop=%b err=%b want drop=0000010 err=0000000", sv[6:0], ev[6:0]);
    end
    checks++;
    if (out_count !== 8'd6) begin failures++; $display("FAIL t1_count: got %0d want 6", out_count); end
    go_idle();
  endtask

  task automatic test_chained_stuff();
    logic [63:0] vv, dv, sv, ev;
    feed(11, 64'b11111000001, 2, vv, dv, sv, ev);
    checks++;
    if (vv[10:0] !== 11'b11111011110) begin failures++; $display("FAIL t2_valid: got %b want 11111011110", vv[10:0]); end
    checks++;
    if (dv[10:0] !== 11'b11111100000) begin failures++; $display("FAIL t2_data: got %b want 11111100000", dv[10:0]); end
    checks++;
    if (sv[10:0] !== 11'b00000100001 || ev[10:0] !== 11'b0) begin
      failures++; $display("FAIL t2_drop_err: got drop=%b err=%b want drop=00000100001 err=0", sv[10:0], ev[10:0]);
    end
    checks++;
    if (out_count !== 8'd9) begin failures++; $display("FAIL t2_count: got %0d want 9", out_count); end
    go_idle();
  endtask

  task automatic test_stuff_error();
    logic [63:0] vv, dv, sv, ev;
    feed(8, 64'hFF, 0, vv, dv, sv, ev);
    checks++;
    if (vv[7:0] !== 8'b11111000) begin failures++; $display("FAIL t3_valid: got %b want 11111000", vv[7:0]); end
    checks++;
    if (ev[7:0] !== 8'b00000111 || sv[7:0] !== 8'b0) begin
      failures++; $display("FAIL t3_err_hold: got err=%b drop=%b want err=00000111 drop=0", ev[7:0], sv[7:0]);
    end
    checks++;
    if (out_count !== 8'd5) begin failures++; $display("FAIL t3_count_frozen: got %0d want 5", out_count); end
    go_idle();
    checks++;
    if (stuff_error !== 1'b0 || out_count !== 8'd0 || bit_out_valid !== 1'b0) begin
      failures++; $display("FAIL t3_clear: got err=%b cnt=%0d vld=%b want err=0 cnt=0 vld=0", stuff_error, out_count, bit_out_valid);
    end
  endtask

  task automatic test_enable_restart();
    logic [63:0] vv, dv, sv, ev;
    feed(4, 64'b0000, 0, vv, dv, sv, ev);
    checks++;
    if (vv[3:0] !== 4'b1111) begin failures++; $display("FAIL t4_first_run: got %b want 1111", vv[3:0]); end
    // A bit offered while enable is low must be ignored.
    @(negedge clk);
    enable = 1'b0; bit_in = 1'b0; bit_valid = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bit_out_valid !== 1'b0 || stuff_drop !== 1'b0 || out_count !== 8'd0) begin
      failures++; $display("FAIL t4_disabled_bit: got vld=%b drop=%b cnt=%0d want 0 0 0", bit_out_valid, stuff_drop, out_count);
    end
    feed(6, 64'b000000, 0, vv, dv, sv, ev);
    checks++;
    if (vv[5:0] !== 6'b111110 || ev[5:0] !== 6'b000001) begin
      failures++; $display("FAIL t4_second_run: got vld=%b err=%b want vld=111110 err=000001", vv[5:0], ev[5:0]);
    end
    checks++;
    if (out_count !== 8'd5) begin failures++; $display("FAIL t4_count: got %0d want 5", out_count); end
    go_idle();
  endtask

  task automatic test_async_reset();
    logic [63:0] vv, dv, sv, ev;
    feed(3, 64'b000, 0, vv, dv, sv, ev);
    checks++;
    if (out_count !== 8'd3 || bit_out !== 1'b0) begin
      failures++; $display("FAIL t5_pre_reset: got cnt=%0d out=%b want cnt=3 out=0", out_count, bit_out);
    end
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if ({bit_out, bit_out_valid, stuff_drop, stuff_error, out_count} !== {4'b1000, 8'd0}) begin
      failures++;
      $display("FAIL t5_async_reset: got out=%b vld=%b drop=%b err=%b cnt=%0d, want out=1 vld=0 drop=0 err=0 cnt=0",
               bit_out, bit_out_valid, stuff_drop, stuff_error, out_count);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (bit_out_valid !== 1'b0 || stuff_drop !== 1'b0 || stuff_error !== 1'b0) begin
      failures++; $display("FAIL t5_no_strobe: got vld=%b drop=%b err=%b want 0 0 0", bit_out_valid, stuff_drop, stuff_error);
    end
    feed(6, 64'b000000, 0, vv, dv, sv, ev);
    checks++;
    if (vv[5:0] !== 6'b111110 || ev[5:0] !== 6'b000001) begin
      failures++; $display("FAIL t5_fresh_run: got vld=%b err=%b want vld=111110 err=000001", vv[5:0], ev[5:0]);
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    logic [63:0] vv, dv, sv, ev;
    logic [31:0] rx;
    int          nrx;
    // Stuffed form of 32'hFF00FF00: 11111 0 111 00000 1 000 11111 0 111 00000 1 000
    feed(36, 64'hF_B823_EE08, 0, vv, dv, sv, ev);
    rx  = '0;
    nrx = 0;
    for (int i = 35; i >= 0; i--) begin
      if (vv[i]) begin
        rx = {rx[30:0], dv[i]};
        nrx++;
      end
    end
    checks++;
    if (nrx != 32 || rx !== 32'hFF00FF00) begin
      failures++; $display("FAIL t6_data: got %0d bits %h want 32 bits ff00ff00", nrx, rx);
    end
    checks++;
    if ($countones(sv[35:0]) != 4) begin failures++; $display("FAIL t6_drops: got %0d want 4", $countones(sv[35:0])); end
    checks++;
    if (ev[35:0] !== 36'd0 || stuff_error !== 1'b0) begin failures++; $display("FAIL t6_error: got %h want 0", ev[35:0]); end
    checks++;
    if (out_count !== 8'd32) begin failures++; $display("FAIL t6_count: got %0d want 32", out_count); end
    go_idle();
  endtask

  initial begin
    test_reset();
    test_single_stuff();
    test_chained_stuff();
    test_stuff_error();
    test_enable_restart();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
